dtree_feature_framer: RTL

- Upstream stage of the cardio decision-tree classifier.
- Receives raw 8-bit features as a byte stream: one frame = 20 bytes, feature 0 first, marked by start-of-frame.
- Drops the feature indices the tree does not use (4 and 5), assembles the remaining 18 features into a parallel vector on X0..X3, X6..X19, and holds that vector stable for the combinational tree until the consumer accepts it.
- Reports frame-sync errors.

---
 rtl/dtree_feature_framer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dtree_feature_framer.sv
// Byte-stream framer for the cardio decision tree: collects a 20-byte frame,
// drops the unused features 4 and 5, and holds the parallel vector until released.
module dtree_feature_framer #(
  parameter int                 N_RAW     = 20,
  parameter logic [N_RAW-1:0]   DROP_MASK = 20'h00030
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_sof,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] X0,
  output logic [7:0] X1,
  output logic [7:0] X2,
  output logic [7:0] X3,
  output logic [7:0] X6,
  output logic [7:0] X7,
  output logic [7:0] X8,
  output logic [7:0] X9,
  output logic [7:0] X10,
  output logic [7:0] X11,
  output logic [7:0] X12,
  output logic [7:0] X13,
  output logic [7:0] X14,
  output logic [7:0] X15,
  output logic [7:0] X16,
  output logic [7:0] X17,
  output logic [7:0] X18,
  output logic [7:0] X19,
  output logic       vec_valid,
  input  logic       vec_ready,
  output logic       sync_err,
  output logic [15:0] frame_cnt
);

  localparam int         IDX_W    = 5;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_RAW - 1);

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             in_ready_q;
  logic             vec_valid_q;
  logic             sync_err_q;
  logic [15:0]      frame_cnt_q;
  logic [7:0]       feat_q [N_RAW];

  logic             xfer;
  logic             wr_en_d;
  logic [IDX_W-1:0] wr_idx_d;

  assign xfer = in_valid & in_ready_q;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    wr_en_d  = 1'b0;
    wr_idx_d = idx_q;
    if (xfer) begin
      if (in_sof) begin
        wr_en_d  = (state_q == HUNT) || (state_q == FILL);
        wr_idx_d = '0;
      end else begin
        wr_en_d  = (state_q == FILL);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      vec_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      case (state_q)
        HUNT: begin
          in_ready_q <= 1'b1;
          if (xfer && in_sof) begin
            idx_q   <= IDX_W'(1);
            state_q <= FILL;
          end
        end
        FILL: begin
          if (xfer) begin
            if (in_sof) begin
              // A new start-of-frame restarts assembly; stale features stay until overwritten.
              if (idx_q != '0) sync_err_q <= 1'b1;
              idx_q <= IDX_W'(1);
            end else if (idx_q == LAST_IDX) begin
              idx_q       <= '0;
              vec_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
              state_q     <= HOLD;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (vec_ready && vec_valid_q) begin
            vec_valid_q <= 1'b0;
            frame_cnt_q <= frame_cnt_q + 16'd1;
            in_ready_q  <= 1'b1;
            state_q     <= HUNT;
          end
        end
        default: begin
          state_q    <= HUNT;
          idx_q      <= '0;
          in_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the feature registers drive the tree directly and must read zero out of
  // reset, so this storage is reset even though it is array-shaped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_RAW; i++) feat_q[i] <= 8'h00;
    end else if (wr_en_d) begin
      for (int i = 0; i < N_RAW; i++) begin
        if (!DROP_MASK[i] && (wr_idx_d == IDX_W'(i))) feat_q[i] <= in_data;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign vec_valid = vec_valid_q;
  assign sync_err  = sync_err_q;
  assign frame_cnt = frame_cnt_q;

  assign X0  = feat_q[0];
  assign X1  = feat_q[1];
  assign X2  = feat_q[2];
  assign X3  = feat_q[3];
  assign X6  = feat_q[6];
  assign X7  = feat_q[7];
  assign X8  = feat_q[8];
  assign X9  = feat_q[9];
  assign X10 = feat_q[10];
  assign X11 = feat_q[11];
  assign X12 = feat_q[12];
  assign X13 = feat_q[13];
  assign X14 = feat_q[14];
  assign X15 = feat_q[15];
  assign X16 = feat_q[16];
  assign X17 = feat_q[17];
  assign X18 = feat_q[18];
  assign X19 = feat_q[19];

endmodule
